// File: rtl/exec_pkg.sv
// Shared definitions for the execute/writeback stage: op encodings,
// FSM state type and default widths matching the 2R/1W register file.
// Optional feature macro: EXEC_MUL_EN (iterative multiplier for op 7).
package exec_pkg;

  localparam int EXEC_DATA_W = 8;
  localparam int EXEC_ADDR_W = 2;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_SHL1 = 3'd5;
  localparam logic [2:0] OP_MOV  = 3'd6;
  localparam logic [2:0] OP_MUL  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ALU  = 2'd1,
    ST_MUL  = 2'd2
  } exec_state_e;

endpackage

// File: rtl/exec_alu.sv
// Combinational single-cycle ALU. Op 7 falls through to MOV here; when the
// iterative multiplier is built in, op 7 never reaches this unit's output.
module exec_alu
  import exec_pkg::*;
#(
  parameter int DATA_W = EXEC_DATA_W
) (
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              carry
);

  logic [DATA_W:0] sum_ext;
  logic [DATA_W:0] diff_ext;

  // Extra MSB holds carry-out for ADD and borrow (a < b) for SUB.
  assign sum_ext  = {1'b0, a} + {1'b0, b};
  assign diff_ext = {1'b0, a} - {1'b0, b};

  // Result and carry select by op; carry is 0 for logical ops and MOV.
  always_comb begin
    result = a;
    carry  = 1'b0;
    case (op)
      OP_ADD: begin
        result = sum_ext[DATA_W-1:0];
        carry  = sum_ext[DATA_W];
      end
      OP_SUB: begin
        result = diff_ext[DATA_W-1:0];
        carry  = diff_ext[DATA_W];
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_SHL1: begin
        result = {a[DATA_W-2:0], 1'b0};
        carry  = a[DATA_W-1];
      end
      default: begin
        result = a;
        carry  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/exec_wb_stage.sv
// Execute/writeback stage sitting below the 2R/1W register file.
// p0 = accept cycle (operand read + forwarding), p1 = EX, then WB registers.
// Optional feature macro: EXEC_MUL_EN -- op 7 runs as an iterative
// shift-add multiply; without it op 7 behaves as MOV and in_ready is tied 1.
module exec_wb_stage
  import exec_pkg::*;
#(
  parameter int DATA_W = EXEC_DATA_W,
  parameter int ADDR_W = EXEC_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic [ADDR_W-1:0] in_rs0,
  input  logic [ADDR_W-1:0] in_rs1,
  output logic [ADDR_W-1:0] raddr0,
  output logic [ADDR_W-1:0] raddr1,
  input  logic [DATA_W-1:0] rdata0,
  input  logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic              wren,
  output logic              flag_z,
  output logic              flag_c,
  output logic              busy
);

  exec_state_e       state;
  logic              accept_p0;
  logic [DATA_W-1:0] opa_p0;
  logic [DATA_W-1:0] opb_p0;
  logic [2:0]        op_p1;
  logic [ADDR_W-1:0] rd_p1;
  logic [DATA_W-1:0] a_p1;
  logic [DATA_W-1:0] b_p1;
  logic              vld_p1;
  logic [DATA_W-1:0] alu_res_p1;
  logic              alu_c_p1;

`ifdef EXEC_MUL_EN
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  logic [CNT_W-1:0]  mul_cnt;
  logic [DATA_W-1:0] mul_acc;
  logic [DATA_W-1:0] mul_sum;

  // One shifted copy of the multiplicand per set multiplier bit, truncated
  // to DATA_W so the running sum stays modulo 2^DATA_W.
  function automatic logic [DATA_W-1:0] partial_product(
    input logic [DATA_W-1:0] a,
    input logic              bit_b,
    input logic [CNT_W-1:0]  sh
  );
    return bit_b ? (a << sh) : '0;
  endfunction

  assign mul_sum  = mul_acc + partial_product(a_p1, b_p1[mul_cnt], mul_cnt);
  assign in_ready = (state != ST_MUL);
`else
  assign in_ready = 1'b1;
`endif

  assign raddr0    = in_rs0;
  assign raddr1    = in_rs1;
  assign busy      = (state != ST_IDLE);
  assign accept_p0 = in_valid & in_ready;
  // Only a single-cycle op in EX has a result ready to forward.
  assign vld_p1    = (state == ST_ALU);

  // Forwarding priority: newest (EX) over WB over register file contents.
  assign opa_p0 = (vld_p1 && (rd_p1 == in_rs0)) ? alu_res_p1 :
                  (wren && (waddr == in_rs0))   ? wdata      : rdata0;
  assign opb_p0 = (vld_p1 && (rd_p1 == in_rs1)) ? alu_res_p1 :
                  (wren && (waddr == in_rs1))   ? wdata      : rdata1;

  // ---- p0 -> p1: latch op, destination and forwarded operands on accept
  always_ff @(posedge clk) begin
    if (accept_p0) begin
      op_p1 <= in_op;
      rd_p1 <= in_rd;
      a_p1  <= opa_p0;
      b_p1  <= opb_p0;
    end
  end

  exec_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .op     (op_p1),
    .a      (a_p1),
    .b      (b_p1),
    .result (alu_res_p1),
    .carry  (alu_c_p1)
  );

  // ---- p1 -> WB: FSM, multiplier iteration and registered writeback/flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      wren   <= 1'b0;
      waddr  <= '0;
      wdata  <= '0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
`ifdef EXEC_MUL_EN
      mul_cnt <= '0;
`endif
    end else begin
      wren <= 1'b0;
      case (state)
        ST_ALU: begin
          waddr  <= rd_p1;
          wdata  <= alu_res_p1;
          wren   <= 1'b1;
          flag_z <= (alu_res_p1 == '0);
          flag_c <= alu_c_p1;
        end
`ifdef EXEC_MUL_EN
        ST_MUL: begin
          mul_acc <= mul_sum;
          mul_cnt <= mul_cnt + CNT_W'(1);
          if (mul_cnt == CNT_LAST) begin
            waddr  <= rd_p1;
            wdata  <= mul_sum;
            wren   <= 1'b1;
            flag_z <= (mul_sum == '0);
            flag_c <= 1'b0;
          end
        end
`endif
        default: ;
      endcase

`ifdef EXEC_MUL_EN
      if (state == ST_MUL) begin
        if (mul_cnt == CNT_LAST) begin
          state <= ST_IDLE;
        end
      end else if (accept_p0) begin
        state   <= (in_op == OP_MUL) ? ST_MUL : ST_ALU;
        mul_cnt <= '0;
        mul_acc <= '0;
      end else begin
        state <= ST_IDLE;
      end
`else
      state <= accept_p0 ? ST_ALU : ST_IDLE;
`endif
    end
  end

endmodule

// File: tb/tb_exec_wb_stage.sv
// Directed bench for exec_wb_stage with a behavioural 4x8 register file.
module tb_exec_wb_stage;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_op;
  logic [1:0] in_rd;
  logic [1:0] in_rs0;
  logic [1:0] in_rs1;
  logic [1:0] raddr0;
  logic [1:0] raddr1;
  logic [7:0] rdata0;
  logic [7:0] rdata1;
  logic [1:0] waddr;
  logic [7:0] wdata;
  logic       wren;
  logic       flag_z;
  logic       flag_c;
  logic       busy;

  logic [7:0] rf [4];
  logic [7:0] pl_val [4];
  logic       pl_en;

  int n_chk;
  int n_fail;

  exec_wb_stage #(
    .DATA_W (8),
    .ADDR_W (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_op    (in_op),
    .in_rd    (in_rd),
    .in_rs0   (in_rs0),
    .in_rs1   (in_rs1),
    .raddr0   (raddr0),
    .raddr1   (raddr1),
    .rdata0   (rdata0),
    .rdata1   (rdata1),
    .waddr    (waddr),
    .wdata    (wdata),
    .wren     (wren),
    .flag_z   (flag_z),
    .flag_c   (flag_c),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: preload port for the bench, write port for the DUT.
  always_ff @(posedge clk) begin
    if (pl_en) begin
      for (int i = 0; i < 4; i++) rf[i] <= pl_val[i];
    end else if (wren) begin
      rf[waddr] <= wdata;
    end
  end

  assign rdata0 = rf[raddr0];
  assign rdata1 = rf[raddr1];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] v0, v1, v2, v3);
    pl_val[0] = v0; pl_val[1] = v1; pl_val[2] = v2; pl_val[3] = v3;
    pl_en = 1'b1;
    step();
    pl_en = 1'b0;
  endtask

  task automatic set_instr(input logic [2:0] op, input logic [1:0] rd, rs0, rs1);
    in_valid = 1'b1; in_op = op; in_rd = rd; in_rs0 = rs0; in_rs1 = rs1;
  endtask

  task automatic clr_instr();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b exp 0", busy); end
    n_chk++; if (wren !== 1'b0) begin n_fail++; $display("FAIL rst_wren got %b exp 0", wren); end
    n_chk++; if (waddr !== 2'd0) begin n_fail++; $display("FAIL rst_waddr got %h exp 0", waddr); end
    n_chk++; if (wdata !== 8'h00) begin n_fail++; $display("FAIL rst_wdata got %h exp 00", wdata); end
    n_chk++; if ({flag_z, flag_c} !== 2'b00) begin n_fail++; $display("FAIL rst_flags got %b exp 00", {flag_z, flag_c}); end
    rst = 1'b0;
  endtask

  task automatic test_add();
    preload(8'h05, 8'h00, 8'h00, 8'h00);
    set_instr(3'd0, 2'd1, 2'd0, 2'd0);
    #1;
    n_chk++; if ({raddr0, raddr1} !== 4'b0000) begin n_fail++; $display("FAIL add_raddr got %b exp 0000", {raddr0, raddr1}); end
    step();
    clr_instr();
    n_chk++; if (wren !== 1'b0) begin n_fail++; $display("FAIL add_wren_a1 got %b exp 0", wren); end
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL add_busy got %b exp 1", busy); end
    step();
    n_chk++; if (wren !== 1'b1) begin n_fail++; $display("FAIL add_wren got %b exp 1", wren); end
    n_chk++; if (waddr !== 2'd1) begin n_fail++; $display("FAIL add_waddr got %h exp 1", waddr); end
    n_chk++; if (wdata !== 8'h0A) begin n_fail++; $display("FAIL add_wdata got %h exp 0a", wdata); end
    n_chk++; if ({flag_z, flag_c} !== 2'b00) begin n_fail++; $display("FAIL add_flags got %b exp 00", {flag_z, flag_c}); end
    step();
    n_chk++; if (wren !== 1'b0) begin n_fail++; $display("FAIL add_wren_drop got %b exp 0", wren); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL add_idle got %b exp 0", busy); end
  endtask

  task automatic test_sub_xor();
    preload(8'h03, 8'h05, 8'h00, 8'h00);
    set_instr(3'd1, 2'd2, 2'd0, 2'd1);
    step();
    clr_instr();
    step();
    n_chk++; if (wdata !== 8'hFE || waddr !== 2'd2 || wren !== 1'b1) begin n_fail++; $display("FAIL sub_wb got %b/%h/%h exp 1/2/fe", wren, waddr, wdata); end
    n_chk++; if ({flag_z, flag_c} !== 2'b01) begin n_fail++; $display("FAIL sub_flags got %b exp 01", {flag_z, flag_c}); end
    step();
    n_chk++; if ({wren, flag_c} !== 2'b01) begin n_fail++; $display("FAIL sub_flag_hold got %b exp 01", {wren, flag_c}); end
    set_instr(3'd4, 2'd3, 2'd2, 2'd2);
    step();
    clr_instr();
    step();
    n_chk++; if (wdata !== 8'h00 || waddr !== 2'd3 || wren !== 1'b1) begin n_fail++; $display("FAIL xor_wb got %b/%h/%h exp 1/3/00", wren, waddr, wdata); end
    n_chk++; if ({flag_z, flag_c} !== 2'b10) begin n_fail++; $display("FAIL xor_flags got %b exp 10", {flag_z, flag_c}); end
    step();
  endtask

  task automatic test_ops();
    logic [2:0] op;
    logic [7:0] ed;
    logic       ec;
    preload(8'hA5, 8'h6C, 8'h00, 8'h00);
    for (int i = 0; i < 7; i++) begin
      case (i)
        0: begin op = 3'd0; ed = 8'h11; ec = 1'b1; end
        1: begin op = 3'd1; ed = 8'h39; ec = 1'b0; end
        2: begin op = 3'd2; ed = 8'h24; ec = 1'b0; end
        3: begin op = 3'd3; ed = 8'hED; ec = 1'b0; end
        4: begin op = 3'd4; ed = 8'hC9; ec = 1'b0; end
        5: begin op = 3'd5; ed = 8'h4A; ec = 1'b1; end
        default: begin op = 3'd6; ed = 8'hA5; ec = 1'b0; end
      endcase
      set_instr(op, 2'd2, 2'd0, 2'd1);
      step();
      clr_instr();
      step();
      n_chk++; if (wren !== 1'b1 || wdata !== ed) begin n_fail++; $display("FAIL ops_%0d got %b/%h exp 1/%h", i, wren, wdata, ed); end
      n_chk++; if (flag_c !== ec) begin n_fail++; $display("FAIL ops_c_%0d got %b exp %b", i, flag_c, ec); end
      step();
    end
  endtask

  task automatic test_forward();
    preload(8'h01, 8'h00, 8'h00, 8'h00);
    set_instr(3'd0, 2'd1, 2'd0, 2'd0);
    step();
    set_instr(3'd0, 2'd2, 2'd1, 2'd1);
    step();
    n_chk++; if (wren !== 1'b1 || waddr !== 2'd1 || wdata !== 8'h02) begin n_fail++; $display("FAIL fwd_first got %b/%h/%h exp 1/1/02", wren, waddr, wdata); end
    set_instr(3'd6, 2'd3, 2'd1, 2'd1);
    step();
    clr_instr();
    n_chk++; if (wren !== 1'b1 || waddr !== 2'd2 || wdata !== 8'h04) begin n_fail++; $display("FAIL fwd_ex got %b/%h/%h exp 1/2/04", wren, waddr, wdata); end
    step();
    n_chk++; if (wren !== 1'b1 || waddr !== 2'd3 || wdata !== 8'h02) begin n_fail++; $display("FAIL fwd_wb got %b/%h/%h exp 1/3/02", wren, waddr, wdata); end
    step();
    n_chk++; if (wren !== 1'b0) begin n_fail++; $display("FAIL fwd_drain got %b exp 0", wren); end
  endtask

  task automatic test_back_to_back();
    preload(8'h03, 8'h00, 8'h00, 8'h00);
    set_instr(3'd0, 2'd1, 2'd0, 2'd0);
    step();
    set_instr(3'd0, 2'd1, 2'd1, 2'd1);
    step();
    n_chk++; if (wren !== 1'b1 || waddr !== 2'd1 || wdata !== 8'h06) begin n_fail++; $display("FAIL b2b_w1 got %b/%h/%h exp 1/1/06", wren, waddr, wdata); end
    set_instr(3'd0, 2'd1, 2'd1, 2'd0);
    step();
    clr_instr();
    n_chk++; if (wren !== 1'b1 || waddr !== 2'd1 || wdata !== 8'h0C) begin n_fail++; $display("FAIL b2b_w2 got %b/%h/%h exp 1/1/0c", wren, waddr, wdata); end
    step();
    n_chk++; if (wren !== 1'b1 || waddr !== 2'd1 || wdata !== 8'h0F) begin n_fail++; $display("FAIL b2b_w3 got %b/%h/%h exp 1/1/0f", wren, waddr, wdata); end
    step();
    n_chk++; if (rf[1] !== 8'h0F) begin n_fail++; $display("FAIL b2b_rf got %h exp 0f", rf[1]); end
  endtask

`ifdef EXEC_MUL_EN
  task automatic test_mul();
    int lows;
    preload(8'h00, 8'h0C, 8'h15, 8'h00);
    set_instr(3'd7, 2'd3, 2'd1, 2'd2);
    step();
    set_instr(3'd0, 2'd0, 2'd3, 2'd3);
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mul_busy got %b exp 1", busy); end
    lows = 0;
    while (in_ready === 1'b0 && lows < 20) begin
      lows++;
      step();
    end
    n_chk++; if (lows !== 8) begin n_fail++; $display("FAIL mul_ready_low got %0d cycles exp 8", lows); end
    n_chk++; if (wren !== 1'b1 || waddr !== 2'd3 || wdata !== 8'hFC) begin n_fail++; $display("FAIL mul_wb got %b/%h/%h exp 1/3/fc", wren, waddr, wdata); end
    n_chk++; if ({flag_z, flag_c} !== 2'b00) begin n_fail++; $display("FAIL mul_flags got %b exp 00", {flag_z, flag_c}); end
    step();
    clr_instr();
    n_chk++; if (wren !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL mul_held_accept got %b/%b exp 0/1", wren, busy); end
    step();
    n_chk++; if (wren !== 1'b1 || waddr !== 2'd0 || wdata !== 8'hF8 || flag_c !== 1'b1) begin n_fail++; $display("FAIL mul_next got %b/%h/%h/%b exp 1/0/f8/1", wren, waddr, wdata, flag_c); end
    step();
  endtask

  task automatic test_mul_abort();
    int writes;
    preload(8'h00, 8'h0C, 8'h15, 8'h5A);
    set_instr(3'd7, 2'd3, 2'd1, 2'd2);
    step();
    clr_instr();
    step();
    step();
    step();
    rst = 1'b1;
    step();
    n_chk++; if ({wren, in_ready, busy} !== 3'b010) begin n_fail++; $display("FAIL abort_ctrl got %b exp 010", {wren, in_ready, busy}); end
    n_chk++; if ({flag_z, flag_c} !== 2'b00) begin n_fail++; $display("FAIL abort_flags got %b exp 00", {flag_z, flag_c}); end
    rst = 1'b0;
    writes = 0;
    for (int i = 0; i < 12; i++) begin
      if (wren === 1'b1) writes++;
      step();
    end
    n_chk++; if (writes !== 0) begin n_fail++; $display("FAIL abort_writes got %0d exp 0", writes); end
    n_chk++; if (rf[3] !== 8'h5A) begin n_fail++; $display("FAIL abort_r3 got %h exp 5a", rf[3]); end
  endtask
`else
  task automatic test_op7_mov();
    preload(8'h00, 8'h00, 8'h77, 8'h00);
    set_instr(3'd7, 2'd1, 2'd2, 2'd0);
    step();
    clr_instr();
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL op7_ready_a1 got %b exp 1", in_ready); end
    step();
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL op7_ready_a2 got %b exp 1", in_ready); end
    n_chk++; if (wren !== 1'b1 || waddr !== 2'd1 || wdata !== 8'h77) begin n_fail++; $display("FAIL op7_wb got %b/%h/%h exp 1/1/77", wren, waddr, wdata); end
    n_chk++; if ({flag_z, flag_c} !== 2'b00) begin n_fail++; $display("FAIL op7_flags got %b exp 00", {flag_z, flag_c}); end
    step();
  endtask
`endif

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst = 1'b1;
    pl_en = 1'b0;
    in_valid = 1'b0;
    in_op = 3'd0;
    in_rd = 2'd0;
    in_rs0 = 2'd0;
    in_rs1 = 2'd0;
    for (int i = 0; i < 4; i++) pl_val[i] = 8'h00;
    test_reset();
    test_add();
    test_sub_xor();
    test_ops();
    test_forward();
    test_back_to_back();
`ifdef EXEC_MUL_EN
    test_mul();
    test_mul_abort();
`else
    test_op7_mov();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
